// File: rtl/sprite_compositor.sv
// ============================================================================
// Module  : sprite_compositor
// Purpose : Two-stage priority compositor of N sprite layers over platform /
//           gradient background, with optional per-layer frame-counted hit
//           flash (enabled by defining SPRITE_COMPOSITOR_FLASH_EN).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sprite_compositor #(
    parameter int          N_LAYERS     = 3,
    parameter logic [9:0]  PLATFORM_Y   = 10'd380,
    parameter logic [23:0] PLATFORM_RGB = 24'h00FF00,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [23:0] FLASH_RGB    = 24'hFF0000
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_start,
    input  logic                     pixel_valid,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic [N_LAYERS-1:0]      layer_hit,
    input  logic [24*N_LAYERS-1:0]   layer_rgb,
    input  logic [N_LAYERS-1:0]      flash_trig,
    output logic [7:0]               VGA_R,
    output logic [7:0]               VGA_G,
    output logic [7:0]               VGA_B,
    output logic                     out_valid,
    output logic [N_LAYERS-1:0]      flash_active
);

    localparam int WIN_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    // ------------------------------------------------------------------
    // Stage 1: background, priority select, winner colour
    // ------------------------------------------------------------------
    logic [7:0]       bg_blue;
    logic [23:0]      bg_rgb;
    logic [WIN_W-1:0] win_d,     win_q;
    logic             any_hit_d, any_hit_q;
    logic [23:0]      rgb1_d,    rgb1_q;
    logic             valid1_d,  valid1_q;

    always_comb begin
        bg_blue = 8'h7F - {1'b0, DrawX[9:3]};
        bg_rgb  = (DrawY >= PLATFORM_Y) ? PLATFORM_RGB : {8'h3F, 8'h00, bg_blue};
    end

    // Scan from lowest priority upward so the lowest hitting index wins.
    always_comb begin
        win_d     = '0;
        any_hit_d = 1'b0;
        rgb1_d    = bg_rgb;
        valid1_d  = pixel_valid;
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_hit[i]) begin
                win_d     = WIN_W'(i);
                any_hit_d = 1'b1;
                rgb1_d    = layer_rgb[24*i +: 24];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            win_q     <= '0;
            any_hit_q <= 1'b0;
            rgb1_q    <= '0;
            valid1_q  <= 1'b0;
        end else begin
            win_q     <= win_d;
            any_hit_q <= any_hit_d;
            rgb1_q    <= rgb1_d;
            valid1_q  <= valid1_d;
        end
    end

    // ------------------------------------------------------------------
    // Flash counters
    // ------------------------------------------------------------------
    logic flash_bit;

`ifdef SPRITE_COMPOSITOR_FLASH_EN
    logic [7:0]          cnt_d [N_LAYERS];
    logic [7:0]          cnt_q [N_LAYERS];
    logic [N_LAYERS-1:0] active_d, active_q;
    logic                unused_flash_ok;

    // A trigger reloads and masks the frame decrement in the same cycle.
    always_comb begin
        for (int i = 0; i < N_LAYERS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flash_trig[i]) begin
                cnt_d[i] = 8'(FLASH_FRAMES);
            end else if (frame_start && (cnt_q[i] != 8'd0)) begin
                cnt_d[i] = cnt_q[i] - 8'd1;
            end
            active_d[i] = (cnt_d[i] != 8'd0);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_LAYERS; i++) begin
                cnt_q[i] <= 8'd0;
            end
            active_q <= '0;
        end else begin
            for (int i = 0; i < N_LAYERS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            active_q <= active_d;
        end
    end

    // Odd counter values are the blink-on frames.
    always_comb begin
        flash_bit = 1'b0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (win_q == WIN_W'(i)) begin
                flash_bit = cnt_q[i][0];
            end
        end
    end

    assign flash_active    = active_q;
    assign unused_flash_ok = ^DrawX[2:0];
`else
    logic unused_flash_ok;

    assign flash_bit       = 1'b0;
    assign flash_active    = '0;
    assign unused_flash_ok = ^{DrawX[2:0], flash_trig, frame_start, win_q};
`endif

    // ------------------------------------------------------------------
    // Stage 2: flash substitution and blanking
    // ------------------------------------------------------------------
    logic [23:0] vga_d, vga_q;
    logic        out_valid_d, out_valid_q;

    always_comb begin
        vga_d       = 24'h000000;
        out_valid_d = valid1_q;
        if (valid1_q) begin
            vga_d = (any_hit_q && flash_bit) ? FLASH_RGB : rgb1_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vga_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            vga_q       <= vga_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign VGA_R     = vga_q[23:16];
    assign VGA_G     = vga_q[15:8];
    assign VGA_B     = vga_q[7:0];
    assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_compositor.sv
// ============================================================================
// Module  : tb_sprite_compositor
// Purpose : Directed self-checking bench for sprite_compositor (flash or
//           no-flash build, selected by SPRITE_COMPOSITOR_FLASH_EN).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sprite_compositor;

`ifdef SPRITE_COMPOSITOR_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic        pixel_valid;
    logic [9:0]  DrawX, DrawY;
    logic [2:0]  layer_hit;
    logic [71:0] layer_rgb;
    logic [2:0]  flash_trig;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        out_valid;
    logic [2:0]  flash_active;

    logic [23:0] rgb0, rgb1, rgb2;
    int          n_checks = 0;
    int          n_fail   = 0;

    assign layer_rgb = {rgb2, rgb1, rgb0};

    always #5 Clk = ~Clk;

    sprite_compositor dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_start  (frame_start),
        .pixel_valid  (pixel_valid),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .layer_hit    (layer_hit),
        .layer_rgb    (layer_rgb),
        .flash_trig   (flash_trig),
        .VGA_R        (VGA_R),
        .VGA_G        (VGA_G),
        .VGA_B        (VGA_B),
        .out_valid    (out_valid),
        .flash_active (flash_active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] fl(input logic [23:0] rgb);
        return FLASH_ON ? 24'hFF0000 : rgb;
    endfunction

    function automatic logic [2:0] act(input logic [2:0] m);
        return FLASH_ON ? m : 3'b000;
    endfunction

    // Present one pixel for one cycle, then check the output two cycles later.
    task automatic pix(input string tag, input logic v, input logic [9:0] x,
                       input logic [9:0] y, input logic [2:0] hit, input logic [23:0] exp);
        pixel_valid = v;
        DrawX       = x;
        DrawY       = y;
        layer_hit   = hit;
        @(negedge Clk);
        pixel_valid = 1'b0;
        layer_hit   = 3'b000;
        @(negedge Clk);
        check({tag, "_rgb"}, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp});
        check({tag, "_vld"}, {31'h0, out_valid}, {31'h0, v});
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    task automatic trig(input logic [2:0] m);
        flash_trig = m;
        @(negedge Clk);
        flash_trig = 3'b000;
    endtask

    initial begin
        Reset       = 1'b1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        layer_hit   = '0;
        flash_trig  = '0;
        rgb0        = 24'h123456;
        rgb1        = 24'hFFFFFF;
        rgb2        = 24'h000000;

        repeat (3) @(negedge Clk);
        check("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        check("rst_vld", {31'h0, out_valid}, 32'h0);
        check("rst_act", {29'h0, flash_active}, 32'h0);
        Reset = 1'b0;
        @(negedge Clk);

        // Stream a line with a pending flash, then reset mid-line
        trig(3'b100);
        for (int i = 0; i < 5; i++) begin
            pixel_valid = 1'b1;
            DrawX       = 10'(i * 8);
            DrawY       = 10'd5;
            @(negedge Clk);
        end
        check("pre_rst_vld", {31'h0, out_valid}, 32'h1);
        check("pre_rst_act", {29'h0, flash_active}, {29'h0, act(3'b100)});
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        check("midrst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        check("midrst_vld", {31'h0, out_valid}, 32'h0);
        check("midrst_act", {29'h0, flash_active}, 32'h0);
        @(negedge Clk);
        pixel_valid = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // First pixel after reset: exactly two cycles of latency
        pixel_valid = 1'b1;
        DrawX       = 10'd0;
        DrawY       = 10'd0;
        @(negedge Clk);
        pixel_valid = 1'b0;
        check("lat1_vld", {31'h0, out_valid}, 32'h0);
        @(negedge Clk);
        check("lat2_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h003F007F);
        check("lat2_vld", {31'h0, out_valid}, 32'h1);
        @(negedge Clk);
        check("lat3_vld", {31'h0, out_valid}, 32'h0);

        // Background gradient and platform band
        pix("bg_639", 1'b1, 10'd639, 10'd379, 3'b000, 24'h3F0030);
        pix("bg_100", 1'b1, 10'd100, 10'd200, 3'b000, 24'h3F0073);
        pix("plat",   1'b1, 10'd639, 10'd380, 3'b000, 24'h00FF00);
        pix("blank",  1'b0, 10'd10,  10'd10,  3'b111, 24'h000000);

        // Priority
        pix("pri_110", 1'b1, 10'd50, 10'd50, 3'b110, 24'hFFFFFF);
        pix("pri_111", 1'b1, 10'd50, 10'd50, 3'b111, 24'h123456);
        pix("pri_100", 1'b1, 10'd50, 10'd50, 3'b100, 24'h000000);

        // Flash sequence on layer 1
        rgb1 = 24'hABCDEF;
        trig(3'b010);
        check("fl_act_rise", {29'h0, flash_active}, {29'h0, act(3'b010)});
        frame_pulse();
        pix("fl_f1", 1'b1, 10'd60, 10'd60, 3'b010, fl(24'hABCDEF));
        frame_pulse();
        pix("fl_f2", 1'b1, 10'd60, 10'd60, 3'b010, 24'hABCDEF);
        repeat (5) frame_pulse();
        check("fl_act_f7", {29'h0, flash_active}, {29'h0, act(3'b010)});
        pix("fl_f7", 1'b1, 10'd60, 10'd60, 3'b010, fl(24'hABCDEF));
        frame_pulse();
        check("fl_act_f8", {29'h0, flash_active}, 32'h0);
        pix("fl_f8", 1'b1, 10'd60, 10'd60, 3'b010, 24'hABCDEF);

        // Trigger and frame_start together: load wins (counter 8, then 7)
        flash_trig  = 3'b001;
        frame_start = 1'b1;
        @(negedge Clk);
        flash_trig  = 3'b000;
        frame_start = 1'b0;
        check("same_act", {29'h0, flash_active}, {29'h0, act(3'b001)});
        pix("same_c8", 1'b1, 10'd70, 10'd70, 3'b001, 24'h123456);
        frame_pulse();
        pix("same_c7", 1'b1, 10'd70, 10'd70, 3'b001, fl(24'h123456));

        // Layer 1 flashing while hidden under an even-count layer 0
        trig(3'b010);
        check("hid_act", {29'h0, flash_active}, {29'h0, act(3'b011)});
        frame_pulse();
        rgb2 = 24'h445566;
        pix("hid_011", 1'b1, 10'd80, 10'd80, 3'b011, 24'h123456);
        pix("hid_010", 1'b1, 10'd80, 10'd80, 3'b010, fl(24'hABCDEF));
        pix("idle_100", 1'b1, 10'd80, 10'd80, 3'b100, 24'h445566);
        pix("nohit_bg", 1'b1, 10'd0,  10'd0,  3'b000, 24'h3F007F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
